// File: rtl/branch_pc_ctrl.sv
// Program-counter and branch-resolution controller.
// Resolves conditional branches, JAL and JALR against the comparator
// flags, owns the PC, raises a one-cycle fetch flush after every redirect,
// traps on misaligned targets or illegal branch encodings, and counts
// retired / taken conditional branches.
module branch_pc_ctrl #(
  parameter int unsigned WIDTH_DATA_LENGTH = 32,
  parameter logic [WIDTH_DATA_LENGTH-1:0] RESET_PC = '0,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         is_branch,
  input  logic                         is_jal,
  input  logic                         is_jalr,
  input  logic [2:0]                   funct3,
  input  logic [WIDTH_DATA_LENGTH-1:0] target,
  input  logic                         BrEq,
  input  logic                         BrLT,
  output logic                         BrUn,
  output logic                         PCSel,
  output logic [WIDTH_DATA_LENGTH-1:0] pc,
  output logic [WIDTH_DATA_LENGTH-1:0] pc_plus4,
  output logic                         flush,
  output logic [1:0]                   err_code,
  output logic [CNT_WIDTH-1:0]         br_cnt,
  output logic [CNT_WIDTH-1:0]         taken_cnt
);

  localparam int unsigned W = WIDTH_DATA_LENGTH;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [W-1:0]         pc_nxt;
  logic                 flush_nxt;
  logic [1:0]           err_nxt;
  logic [CNT_WIDTH-1:0] br_nxt, taken_nxt;

  logic                 run;
  logic                 cond;
  logic                 cond_branch;
  logic                 take;
  logic                 fault_mis;
  logic                 fault_ill;
  logic                 fault;
  logic [W-1:0]         eff_target;

  assign pc_plus4 = pc + W'(4);

  // Decode the current instruction: branch condition, effective target,
  // redirect decision and fault detection.
  always_comb begin
    run         = (state == S_RUN);
    BrUn        = funct3[1];
    cond        = 1'b0;
    case (funct3)
      3'b000:  cond = BrEq;
      3'b001:  cond = !BrEq;
      3'b100:  cond = BrLT;
      3'b101:  cond = !BrLT;
      3'b110:  cond = BrLT;
      3'b111:  cond = !BrLT;
      default: cond = 1'b0;  // 010/011 never redirect; they fault instead
    endcase
    // JAL outranks JALR, so bit 0 is cleared only for a lone JALR.
    eff_target  = target;
    if (!is_jal && is_jalr) begin
      eff_target[0] = 1'b0;
    end
    cond_branch = is_branch && !is_jal && !is_jalr;
    take        = run && (is_jal || is_jalr || (is_branch && cond));
    fault_mis   = take && (eff_target[1:0] != 2'b00);
    fault_ill   = run && cond_branch && (funct3[2:1] == 2'b01);
    fault       = fault_mis || fault_ill;
    PCSel       = take && !fault;
  end

  // Next-state, PC, flush, error and counter update; a stall holds everything.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    flush_nxt = flush;
    err_nxt   = err_code;
    br_nxt    = br_cnt;
    taken_nxt = taken_cnt;
    if (!stall) begin
      case (state)
        S_RUN: begin
          if (fault) begin
            state_nxt = S_TRAP;
            err_nxt   = fault_mis ? 2'b01 : 2'b10;
          end else begin
            if (cond_branch) begin
              br_nxt = br_cnt + CNT_WIDTH'(1);
              if (cond) begin
                taken_nxt = taken_cnt + CNT_WIDTH'(1);
              end
            end
            if (PCSel) begin
              pc_nxt    = eff_target;
              state_nxt = S_FLUSH;
              flush_nxt = 1'b1;
            end else begin
              pc_nxt = pc_plus4;
            end
          end
        end
        S_FLUSH: begin
          pc_nxt    = pc_plus4;
          state_nxt = S_RUN;
          flush_nxt = 1'b0;
        end
        default: begin
          // Trapped: everything frozen until reset.
          state_nxt = S_TRAP;
        end
      endcase
    end
  end

  // State, PC, flush, error and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      err_code  <= 2'b00;
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      flush     <= flush_nxt;
      err_code  <= err_nxt;
      br_cnt    <= br_nxt;
      taken_cnt <= taken_nxt;
    end
  end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Bench for branch_pc_ctrl: a table of decode vectors, directed multi-cycle
// sequences and randomized traffic, all checked against a behavioural model.
module tb_branch_pc_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, is_branch, is_jal, is_jalr;
  logic [2:0]    funct3;
  logic [31:0]   target;
  logic          BrEq, BrLT;
  logic          BrUn, PCSel;
  logic [31:0]   pc, pc_plus4;
  logic          flush;
  logic [1:0]    err_code;
  logic [CW-1:0] br_cnt, taken_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [31:0]   m_pc;
  bit            m_flush, m_trap;
  logic [1:0]    m_err;
  logic [CW-1:0] m_br, m_tk;

  always #5 clk = ~clk;

  branch_pc_ctrl #(
    .WIDTH_DATA_LENGTH(32),
    .RESET_PC(32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3), .target(target),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn), .PCSel(PCSel), .pc(pc),
    .pc_plus4(pc_plus4), .flush(flush), .err_code(err_code),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic        br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] tgt;
    logic        eq, lt;
    logic        brun, pcsel;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Branch condition: high funct3 bit picks less-than over equality, low
  // bit inverts it; the two reserved encodings never take.
  function automatic bit m_cond(input logic [2:0] f, input logic eq, input logic lt);
    bit rel;
    if (f == 3'b010 || f == 3'b011) return 1'b0;
    rel = f[2] ? lt : eq;
    return f[0] ? !rel : rel;
  endfunction

  task automatic m_eval(output bit take, output bit fm, output bit fi, output logic [31:0] eff);
    bit active;
    active = !m_flush && !m_trap;
    eff = target;
    if (!is_jal && is_jalr) eff[0] = 1'b0;
    take = active && (is_jal || is_jalr || (is_branch && m_cond(funct3, BrEq, BrLT)));
    fm = take && (eff % 4 != 0);
    fi = active && is_branch && !is_jal && !is_jalr && (funct3 == 3'd2 || funct3 == 3'd3);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_flush = 0; m_trap = 0; m_err = 2'b00; m_br = '0; m_tk = '0;
  endtask

  task automatic model_step();
    bit take, fm, fi;
    logic [31:0] eff;
    m_eval(take, fm, fi, eff);
    if (stall || m_trap) return;
    if (m_flush) begin
      m_pc = m_pc + 32'd4;
      m_flush = 0;
      return;
    end
    if (fm || fi) begin
      m_trap = 1;
      m_err = fm ? 2'b01 : 2'b10;
      return;
    end
    if (is_branch && !is_jal && !is_jalr) begin
      m_br = m_br + 1'b1;
      if (m_cond(funct3, BrEq, BrLT)) m_tk = m_tk + 1'b1;
    end
    if (take) begin
      m_pc = eff;
      m_flush = 1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    bit take, fm, fi;
    logic [31:0] eff;
    m_eval(take, fm, fi, eff);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".flush"}, 32'(flush), 32'(m_flush));
    chk({tag, ".err_code"}, 32'(err_code), 32'(m_err));
    chk({tag, ".br_cnt"}, 32'(br_cnt), 32'(m_br));
    chk({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(m_tk));
    chk({tag, ".BrUn"}, 32'(BrUn), 32'(funct3[1]));
    chk({tag, ".PCSel"}, 32'(PCSel), 32'(take && !fm && !fi));
  endtask

  task automatic set_in(input logic st, input logic br, input logic jal, input logic jalr,
                        input logic [2:0] f3, input logic [31:0] tgt,
                        input logic eq, input logic lt);
    stall = st; is_branch = br; is_jal = jal; is_jalr = jalr;
    funct3 = f3; target = tgt; BrEq = eq; BrLT = lt;
  endtask

  // One clock: apply inputs, check before the edge, advance model, settle.
  task automatic cyc(input string tag, input logic st, input logic br, input logic jal,
                     input logic jalr, input logic [2:0] f3, input logic [31:0] tgt,
                     input logic eq, input logic lt);
    set_in(st, br, jal, jalr, f3, tgt, eq, lt);
    #1;
    check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 3'b000, 32'h0, 0, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 3'b000, 32'h100, 1, 0, 0, 1};  // BEQ taken
    tbl[1]  = '{1, 0, 0, 3'b000, 32'h100, 0, 0, 0, 0};  // BEQ not taken
    tbl[2]  = '{1, 0, 0, 3'b001, 32'h100, 0, 0, 0, 1};  // BNE taken
    tbl[3]  = '{1, 0, 0, 3'b100, 32'h100, 0, 1, 0, 1};  // BLT taken
    tbl[4]  = '{1, 0, 0, 3'b101, 32'h100, 0, 1, 0, 0};  // BGE not taken
    tbl[5]  = '{1, 0, 0, 3'b110, 32'h100, 0, 1, 1, 1};  // BLTU taken
    tbl[6]  = '{1, 0, 0, 3'b111, 32'h100, 0, 1, 1, 0};  // BGEU not taken
    tbl[7]  = '{1, 0, 0, 3'b111, 32'h100, 0, 0, 1, 1};  // BGEU taken
    tbl[8]  = '{1, 0, 0, 3'b010, 32'h100, 1, 1, 1, 0};  // illegal funct3
    tbl[9]  = '{0, 1, 0, 3'b000, 32'h200, 0, 0, 0, 1};  // JAL
    tbl[10] = '{0, 0, 1, 3'b000, 32'h203, 0, 0, 0, 0};  // JALR misaligned
    tbl[11] = '{0, 0, 1, 3'b000, 32'h101, 0, 0, 0, 1};  // JALR bit0 cleared
    tbl[12] = '{0, 1, 0, 3'b000, 32'h102, 0, 0, 0, 0};  // JAL misaligned
    tbl[13] = '{1, 0, 0, 3'b000, 32'h101, 1, 0, 0, 0};  // BEQ misaligned
    tbl[14] = '{0, 0, 0, 3'b011, 32'h100, 1, 1, 1, 0};  // no instruction

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 3'b000, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Decode table, held under stall so the PC never moves.
    for (int i = 0; i < 15; i++) begin
      set_in(1, tbl[i].br, tbl[i].jal, tbl[i].jalr, tbl[i].f3, tbl[i].tgt, tbl[i].eq, tbl[i].lt);
      #1;
      chk($sformatf("tbl%0d.BrUn", i), 32'(BrUn), 32'(tbl[i].brun));
      chk($sformatf("tbl%0d.PCSel", i), 32'(PCSel), 32'(tbl[i].pcsel));
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("tbl%0d.pc", i), pc, 32'h0);
    end

    // Free-running fetch after reset.
    idle("run0"); chk("run0.pc", pc, 32'h4);
    idle("run1"); chk("run1.pc", pc, 32'h8);
    idle("run2"); chk("run2.pc", pc, 32'hC);
    chk("run2.flush", 32'(flush), 32'h0);

    // BEQ taken, then flush for one cycle.
    cyc("beq", 0, 1, 0, 0, 3'b000, 32'h100, 1, 0);
    chk("beq.pc", pc, 32'h100);
    chk("beq.flush", 32'(flush), 32'h1);
    idle("beq_fl");
    chk("beq_fl.pc", pc, 32'h104);
    chk("beq_fl.flush", 32'(flush), 32'h0);
    chk("beq_fl.br", 32'(br_cnt), 32'h1);
    chk("beq_fl.tk", 32'(taken_cnt), 32'h1);

    // BGEU not taken, then a branch arriving in FLUSH is ignored.
    cyc("bgeu", 0, 1, 0, 0, 3'b111, 32'h500, 0, 1);
    chk("bgeu.pc", pc, 32'h108);
    chk("bgeu.br", 32'(br_cnt), 32'h2);
    chk("bgeu.tk", 32'(taken_cnt), 32'h1);
    cyc("jal", 0, 0, 1, 0, 3'b000, 32'h300, 0, 0);
    cyc("fl_ign", 0, 1, 0, 0, 3'b111, 32'h600, 0, 0);
    chk("fl_ign.pc", pc, 32'h304);
    chk("fl_ign.br", 32'(br_cnt), 32'h2);

    // Stall held through FLUSH.
    cyc("jal2", 0, 0, 1, 0, 3'b000, 32'h400, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 1, 0, 1, 0, 3'b000, 32'h800, 0, 0);
      chk("stall.pc", pc, 32'h400);
      chk("stall.flush", 32'(flush), 32'h1);
    end
    idle("unstall");
    chk("unstall.pc", pc, 32'h404);
    chk("unstall.flush", 32'(flush), 32'h0);

    // pc_plus4 wrap at the top of the address space.
    cyc("jal_top", 0, 0, 1, 0, 3'b000, 32'hFFFF_FFFC, 0, 0);
    chk("top.pc_plus4", pc_plus4, 32'h0);
    idle("top_wrap");
    chk("top_wrap.pc", pc, 32'h0);

    // Counter wrap with 16 taken BNEs.
    pulse_reset("rst_a");
    for (int k = 0; k < 16; k++) begin
      cyc("bne", 0, 1, 0, 0, 3'b001, 32'h40, 0, 0);
      idle("bne_fl");
      if (k == 14) chk("bne15.br", 32'(br_cnt), 32'hF);
    end
    chk("wrap.br", 32'(br_cnt), 32'h0);
    chk("wrap.tk", 32'(taken_cnt), 32'h0);

    // Asynchronous reset in the middle of FLUSH.
    cyc("bne_r", 0, 1, 0, 0, 3'b001, 32'h80, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst.pc", pc, 32'h0);
    chk("arst.flush", 32'(flush), 32'h0);
    model_reset();
    #1;
    rst_n = 1'b1;

    // Misaligned JALR traps; PC and counters frozen.
    cyc("jalr_mis", 0, 0, 0, 1, 3'b000, 32'h203, 0, 0);
    chk("trap.err", 32'(err_code), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc("trap", 0, 1, 0, 0, 3'b000, 32'h100, 1, 0);
      chk("trap.pc", pc, 32'h0);
      chk("trap.br", 32'(br_cnt), 32'h0);
    end

    // Illegal funct3 from a fresh reset.
    pulse_reset("rst_b");
    cyc("ill", 0, 1, 0, 0, 3'b010, 32'h100, 1, 1);
    chk("ill.err", 32'(err_code), 32'h2);
    chk("ill.pc", pc, 32'h0);

    // Randomized traffic against the model.
    pulse_reset("rst_c");
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      if ((m_trap && $urandom_range(0, 2) == 0) || $urandom_range(0, 80) == 0)
        pulse_reset("rnd_rst");
      t = $urandom() & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      cyc("rnd", 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
          3'($urandom_range(0, 7)), t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_pc_ctrl.md
# branch_pc_ctrl

Program-counter and branch-resolution controller for the RISC-V core. Consumes the equal/less-than flags from the branch comparator, drives the comparator's signed/unsigned select back to it, resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, and owns the PC register. It also generates a one-cycle fetch flush after every redirect, traps on illegal or misaligned control flow, and keeps wrap-around branch statistics counters.

## Interface
- WIDTH_DATA_LENGTH, 32, PC/target width
- RESET_PC, 32'h0000_0000, PC value after reset
- CNT_WIDTH, 32, width of statistics counters
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  freeze PC, state and counters this cycle
- is_branch  in  1  current instruction is a conditional branch
- is_jal  in  1  current instruction is JAL
- is_jalr  in  1  current instruction is JALR
- funct3  in  3  branch condition field
- target  in  WIDTH_DATA_LENGTH  ALU-computed target address
- BrEq  in  1  A==B from comparator
- BrLT  in  1  A<B from comparator
- BrUn  out  1  to comparator: 1 = unsigned compare (combinational)
- PCSel  out  1  1 = redirect to target this cycle (combinational)
- pc  out  WIDTH_DATA_LENGTH  current PC (registered)
- pc_plus4  out  WIDTH_DATA_LENGTH  pc + 4, wraps modulo 2^WIDTH
- flush  out  1  squash fetched instruction (registered)
- err_code  out  2  00 none, 01 misaligned target, 10 illegal funct3 (sticky)
- br_cnt  out  CNT_WIDTH  conditional branches retired
- taken_cnt  out  CNT_WIDTH  conditional branches taken

## Operation
- BrUn = funct3[1], independent of state.
- Condition: 000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT; 010/011 illegal.
- Priority: is_jal > is_jalr > is_branch. Effective target = target, with bit 0 cleared for JALR only.
- take = RUN & (is_jal | is_jalr | (is_branch & cond)). PCSel = take & !fault.
- fault_mis = take & eff_target[1]!=0 (bit 0 also for JAL/branch). fault_ill = RUN & is_branch & !is_jal & !is_jalr & funct3 in {010,011}.
- States:
  - RUN: on fault, go to TRAP, latch err_code (misaligned wins if both), PC holds. On PCSel, pc <= eff_target, go to FLUSH. Otherwise pc <= pc_plus4.
  - FLUSH: flush=1. Instruction inputs ignored (no redirect, fault or count). pc <= pc_plus4, return to RUN.
  - TRAP: PC frozen, PCSel=0, flush=0, counters frozen. Exit only by reset.
- Counters: in RUN, non-stalled, non-faulting, is_branch with no jal/jalr: br_cnt += 1; additionally taken_cnt += 1 if cond. Both wrap to 0 at 2^CNT_WIDTH.
- stall=1: no register changes in any state (FLUSH persists, flush stays 1). PCSel still reflects the decision but is not acted on.

## Timing
- Reset (async, rst_n low): pc=RESET_PC, state RUN, flush=0, err_code=00, br_cnt=0, taken_cnt=0. PCSel/BrUn follow the combinational inputs.
- BrUn, PCSel: zero-latency combinational outputs.
- pc updates on the clock edge following the decision; flush is high for exactly the one cycle after a redirect edge (longer only while stalled).
- Back-to-back redirect is impossible: the cycle after a redirect is always FLUSH.
- rst_n deasserting mid-FLUSH/TRAP returns to reset values immediately. Release is synchronous to the next edge.
- pc_plus4 at all-ones-minus-3 wraps to 0.

## Test plan
- Reset, no instructions, 3 edges -> pc 0,4,8,12; flush=0; counters 0.
- BEQ funct3=000, BrEq=1, target=0x100 -> PCSel=1, BrUn=0; next pc=0x100, flush=1 one cycle, then pc=0x104; br_cnt=1, taken_cnt=1.
- BGEU funct3=111, BrLT=1 -> BrUn=1, PCSel=0, pc+4, br_cnt+1, taken_cnt unchanged; same branch during FLUSH -> ignored, no count.
- JALR target=0x203 -> eff 0x202 -> TRAP, err_code=01, pc frozen for 5 cycles; funct3=010 with is_branch (fresh reset) -> err_code=10.
- Stall held 3 cycles during FLUSH -> pc, counters constant, flush stays 1; release -> RUN next edge.
- Preload by running 2^CNT_WIDTH branches (CNT_WIDTH=4: 16 taken BNEs) -> br_cnt and taken_cnt wrap to 0; rst_n pulse mid-FLUSH -> pc=RESET_PC, flush=0 asynchronously.
